// File: rtl/lfsr_stepper.sv
// Fibonacci LFSR advanced by a clock-enable tick divider (free-run) or a single-step edge.
// Optional build macro LFSR_PERIOD_CNT_EN adds period_cnt / wrap_o sequence-wrap tracking.
module lfsr_stepper #(
  parameter int unsigned        WIDTH = 4,
  parameter logic [WIDTH-1:0]   TAPS  = 4'b1100,
  parameter int unsigned        DIV   = 2**27,
  parameter int unsigned        DIV_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic             tick_o,
  output logic             zero_sd
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] period_cnt,
  output logic             wrap_o
`endif
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic             step_q;
  logic             tick_q, tick_d;
  logic             zero_q, zero_d;
  logic             adv_ft, adv_st, adv;
  logic             fb;
  logic [WIDTH-1:0] state_adv;

  // Advance qualification, divider and priority-ordered state update
  always_comb begin
    adv_ft    = run && (divcnt_q == DIV_LAST);
    adv_st    = !run && step && !step_q;
    adv       = adv_ft | adv_st;
    fb        = ^(state_q & TAPS);
    state_adv = {state_q[WIDTH-2:0], fb};

    state_d   = state_q;
    tick_d    = 1'b0;
    zero_d    = zero_q;
    if (!run || adv_ft) divcnt_d = '0;
    else                divcnt_d = divcnt_q + DIV_W'(1);

    if (load) begin
      state_d  = (seed == '0) ? ONE : seed;
      zero_d   = (seed == '0);
      divcnt_d = '0;
    end else if (adv) begin
      state_d  = state_adv;
      tick_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ONE;
      divcnt_q <= '0;
      step_q   <= 1'b0;
      tick_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      step_q   <= step;
      tick_q   <= tick_d;
      zero_q   <= zero_d;
    end
  end

  assign state   = state_q;
  assign tick_o  = tick_q;
  assign zero_sd = zero_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] loaded_q, loaded_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Count advances since load; wrap when the sequence returns to the loaded value
  always_comb begin
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    if (load) begin
      loaded_d = state_d;
      cnt_d    = '0;
    end else if (adv) begin
      if (state_adv == loaded_q) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      loaded_q <= ONE;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  assign period_cnt = cnt_q;
  assign wrap_o     = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_stepper.sv
// Directed bench for lfsr_stepper: DIV=4 instance for step/free-run/load/reset, DIV=1 instance for wrap.
module tb_lfsr_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] seed, seed1;
  logic       load, run, step, load1, run1;
  logic [3:0] state, state1;
  logic       tick_o, zero_sd, tick1, zero1;
`ifdef LFSR_PERIOD_CNT_EN
  logic [3:0] pcnt, pcnt1;
  logic       wrap, wrap1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_stepper #(.WIDTH(4), .TAPS(4'b1100), .DIV(4), .DIV_W(3)) u_dut (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .run(run), .step(step),
    .state(state), .tick_o(tick_o), .zero_sd(zero_sd)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(pcnt), .wrap_o(wrap)
`endif
  );

  lfsr_stepper #(.WIDTH(4), .TAPS(4'b1100), .DIV(1), .DIV_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .seed(seed1), .load(load1), .run(run1), .step(1'b0),
    .state(state1), .tick_o(tick1), .zero_sd(zero1)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(pcnt1), .wrap_o(wrap1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ticks, bad, pbad;
    logic [3:0] st16;
    logic [3:0] exp_st [3];
    exp_st[0] = 4'b0010; exp_st[1] = 4'b0100; exp_st[2] = 4'b1001;

    rst = 1'b0; seed = '0; load = 1'b0; run = 1'b0; step = 1'b0;
    seed1 = '0; load1 = 1'b0; run1 = 1'b0;
    cyc(); cyc();
    check("rst_state", 32'(state), 32'h1);
    check("rst_tick", 32'(tick_o), 32'h0);
    check("rst_zero", 32'(zero_sd), 32'h0);
    rst = 1'b1;
    cyc();
    check("idle_hold", 32'(state), 32'h1);

    // single-step: each pulse held two cycles gives one advance
    seed = 4'b0001; load = 1'b1; cyc(); load = 1'b0;
    ticks = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      cyc(); if (tick_o) ticks++;
      check("step_state", 32'(state), 32'(exp_st[p]));
      cyc(); if (tick_o) ticks++;
      step = 1'b0;
      cyc(); if (tick_o) ticks++;
      cyc(); if (tick_o) ticks++;
    end
    check("step_ticks", 32'(ticks), 32'd3);
    check("step_final", 32'(state), 32'h9);

    // free-run for 60 cycles from seed 0001
    seed = 4'b0001; load = 1'b1; cyc(); load = 1'b0;
    run = 1'b1;
    ticks = 0; bad = 0; st16 = '0;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (tick_o) begin
        ticks++;
        if (i % 4 != 0) bad++;
      end
      if (i == 16) st16 = state;
    end
    check("fr_ticks", 32'(ticks), 32'd15);
    check("fr_phase", 32'(bad), 32'd0);
    check("fr_st16", 32'(st16), 32'h3);
    check("fr_period", 32'(state), 32'h1);

    // load collides with adv_ft: load wins, next tick 4 cycles later
    cyc(); cyc(); cyc();
    seed = 4'b0110; load = 1'b1;
    cyc();
    load = 1'b0;
    check("ld_adv_state", 32'(state), 32'h6);
    check("ld_adv_tick", 32'(tick_o), 32'h0);
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); if (tick_o) ticks++;
    end
    check("ld_adv_gap", 32'(ticks), 32'd0);
    cyc();
    check("ld_adv_next", 32'(tick_o), 32'h1);
    check("ld_adv_nstate", 32'(state), 32'hd);

    // zero seed substitution and sticky flag
    run = 1'b0;
    seed = 4'b0000; load = 1'b1; cyc(); load = 1'b0;
    check("zero_state", 32'(state), 32'h1);
    check("zero_flag", 32'(zero_sd), 32'h1);
    cyc();
    check("zero_sticky", 32'(zero_sd), 32'h1);
    seed = 4'b0110; load = 1'b1; cyc(); load = 1'b0;
    check("nz_state", 32'(state), 32'h6);
    check("nz_flag", 32'(zero_sd), 32'h0);

    // reset mid free-run at divcnt=2
    run = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("mid_rst_state", 32'(state), 32'h1);
    check("mid_rst_tick", 32'(tick_o), 32'h0);
    rst = 1'b1;
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); if (tick_o) ticks++;
    end
    check("mid_rst_div", 32'(ticks), 32'd0);
    cyc();
    check("mid_rst_tick4", 32'(tick_o), 32'h1);
    check("mid_rst_st4", 32'(state), 32'h2);
    run = 1'b0;

    // DIV=1: advance every cycle from seed 1011
    seed1 = 4'b1011; load1 = 1'b1; cyc(); load1 = 1'b0;
    run1 = 1'b1;
    ticks = 0; pbad = 0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (tick1) ticks++;
      if (k == 1) check("d1_first", 32'(state1), 32'h7);
`ifdef LFSR_PERIOD_CNT_EN
      if (k < 15) begin
        if (pcnt1 !== 4'(k) || wrap1 !== 1'b0) pbad++;
      end else begin
        check("wrap_pulse", 32'(wrap1), 32'h1);
        check("wrap_cnt", 32'(pcnt1), 32'h0);
      end
`endif
    end
    run1 = 1'b0;
    check("d1_ticks", 32'(ticks), 32'd15);
    check("d1_period", 32'(state1), 32'hb);
    check("d1_zero", 32'(zero1), 32'h0);
`ifdef LFSR_PERIOD_CNT_EN
    check("pcnt_seq", 32'(pbad), 32'd0);
    cyc();
    check("wrap_clear", 32'(wrap1), 32'h0);
    check("pcnt_main", 32'(pcnt), 32'h1);
    check("wrap_main", 32'(wrap), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
